blur_stream_ctrl: RTL and testbench
===================================

# blur_stream_ctrl

Stream sequencer for the 1-D 4-tap blur stencil pipeline. Sits between the pixel source and the shift-register linebuffer plus multiply/add/shift/clamp datapath. Gates the linebuffer write enable with a valid/ready handshake and tracks column and row position per frame. Asserts output valid only when the stencil window holds a full row-local window, and flags row/frame ends.

## Interface
Parameters:
- TAPS, 4, stencil width in pixels (linebuffer depth + 1)
- LINE_W, 64, pixels per row; must be ≥ TAPS
- NUM_LINES, 64, rows per frame; must be ≥ 1
- COL_W, $clog2(LINE_W), column counter width
- ROW_W, $clog2(NUM_LINES) (min 1), row counter width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  rising-edge clock
- reset  in  1  async active-high reset
- start  in  1  begin a frame; sampled only in IDLE
- clear  in  1  synchronous abort to IDLE; priority over all other inputs
- in_valid  in  1  source pixel valid
- in_ready  out  1  controller accepts a pixel this cycle
- lb_wen  out  1  linebuffer shift enable (= in_valid & in_ready)
- out_valid  out  1  datapath result valid this cycle
- out_ready  in  1  sink accepts result
- out_last  out  1  qualifies out_valid: last result of a row
- out_frame_last  out  1  qualifies out_valid: last result of the frame
- done  out  1  one-cycle pulse after the frame's final transfer
- busy  out  1  high in FILL or STREAM
- col  out  COL_W  column index of the next pixel to accept
- row  out  ROW_W  row index of the next pixel to accept

## Operation
- FSM states: IDLE, FILL, STREAM, DONE.
- IDLE: in_ready = 0. When start = 1, clear col and row and go to FILL.
- FILL: in_ready = 1 regardless of out_ready; out_valid = 0. Each accepted pixel increments col. After the accept at col = TAPS-2, go to STREAM.
- STREAM: in_ready = out_ready, out_valid = in_valid. A transfer is in_valid & out_ready. The datapath tap 0 is the combinational input, so each accepted pixel yields exactly one result in the same cycle.
- Row end is an accept at col = LINE_W-1:
  - out_last = 1 on that result.
  - col wraps to 0 and row increments.
  - If row = NUM_LINES-1, set out_frame_last = 1 and go to DONE; otherwise go to FILL to refill the window. Stale taps from the previous row are shifted out; no linebuffer clear is needed.
- Results per row: LINE_W-TAPS+1. Results per frame: NUM_LINES×(LINE_W-TAPS+1).
- DONE: done = 1 for exactly one cycle, in_ready = 0, then go to IDLE.
- lb_wen = in_valid & in_ready in every state. The linebuffer shifts only when lb_wen = 1.
- start is ignored outside IDLE.
- clear in any state goes to IDLE with col = row = 0. clear overrides a same-cycle accept: no counter update and lb_wen is forced to 0.
- out_last and out_frame_last are 0 whenever out_valid = 0.

## Timing
- Reset values: state IDLE; col = 0; row = 0; in_ready, lb_wen, out_valid, out_last, out_frame_last, done, busy all 0.
- Asynchronous assertion of reset takes effect immediately, including mid-row. Deassertion is synchronized externally.
- in_ready, lb_wen, out_valid, out_last, out_frame_last: combinational from registered state/counters and in_valid/out_ready. out_valid never depends on in_ready (no combinational loop).
- Handshake latency is zero; throughput is one pixel per cycle.
- Fill overhead: TAPS-1 accept cycles per row with no output.
- start → first in_ready: one cycle (state register update).
- Final transfer → done: next cycle. done → IDLE: one cycle. A new start is accepted in IDLE the cycle after done.
- col and row update on the clock edge of each accept.

## Test plan
Use TAPS=4, LINE_W=6, NUM_LINES=2.
- Reset: assert reset mid-simulation → all outputs 0, col = row = 0 immediately, no clock edge required.
- Single row, full throughput: start pulse, in_valid = 1, out_ready = 1 → in_ready high from the next cycle. out_valid is 0 for pixels 0–2 and 1 for pixels 3–5. out_last is high only on pixel 5. col sequence 0,1,2,3,4,5,0.
- Backpressure: during STREAM hold out_ready = 0 for 3 cycles → in_ready = lb_wen = 0 and col holds. During FILL, out_ready = 0 still gives in_ready = 1.
- Full frame: 12 pixels streamed → exactly 6 results, out_last on pixels 5 and 11, out_frame_last only on pixel 11. done pulses for one cycle after pixel 11, then IDLE with busy = 0.
- Restart/abort: start asserted during STREAM → ignored. clear at col = 3, row = 1 → IDLE, col = row = 0, no lb_wen that cycle. A later start processes a full frame correctly.
- Source stalls: in_valid toggling 1,0,1,0 → out_valid mirrors in_valid in STREAM, counters advance only on accepts, and result count is unchanged (6).

Source files
------------

// File: rtl/blur_stream_ctrl.sv
// blur_stream_ctrl: stream sequencer for the 1-D TAPS-tap blur stencil.
// Gates linebuffer shifts with a valid/ready handshake, tracks col/row,
// and qualifies datapath results once a full row-local window is present.
//
// Ports:
//   clk, reset        clock, async active-high reset
//   start, clear      frame start (IDLE only), synchronous abort to IDLE
//   in_valid/in_ready source pixel handshake
//   lb_wen            linebuffer shift enable
//   out_valid/ready   datapath result handshake
//   out_last          last result of a row
//   out_frame_last    last result of the frame
//   done, busy        frame-complete pulse, FILL/STREAM activity
//   col, row          position of the next pixel to accept
module blur_stream_ctrl #(
   parameter int TAPS      = 4,
   parameter int LINE_W    = 64,
   parameter int NUM_LINES = 64,
   parameter int COL_W     = $clog2(LINE_W),
   parameter int ROW_W     = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             lb_wen,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             out_frame_last,
   output logic             done,
   output logic             busy,
   output logic [COL_W-1:0] col,
   output logic [ROW_W-1:0] row
);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      STREAM,
      DONE
   } state_t;

   localparam logic [COL_W-1:0] FILL_END = COL_W'(TAPS - 2);
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_W - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_LINES - 1);

   state_t           state;
   state_t           state_nxt;
   logic [COL_W-1:0] col_nxt;
   logic [ROW_W-1:0] row_nxt;
   logic             row_end;
   logic             last_row;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         col   <= '0;
         row   <= '0;
      end else begin
         state <= state_nxt;
         col   <= col_nxt;
         row   <= row_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      col_nxt        = col;
      row_nxt        = row;
      in_ready       = 1'b0;
      out_valid      = 1'b0;
      row_end        = (col == LAST_COL);
      last_row       = (row == LAST_ROW);

      // Window filling ignores the sink; streaming ties the source
      // directly to the sink since tap 0 is the live input pixel.
      unique case (state)
         FILL:    in_ready = 1'b1;
         STREAM: begin
            in_ready  = out_ready;
            out_valid = in_valid;
         end
         default: ;
      endcase

      // clear suppresses the shift so an aborted pixel never enters
      // the linebuffer.
      lb_wen         = in_valid & in_ready & ~clear;
      out_last       = out_valid & row_end;
      out_frame_last = out_last & last_row;
      done           = (state == DONE);
      busy           = (state == FILL) || (state == STREAM);

      if (clear) begin
         state_nxt = IDLE;
         col_nxt   = '0;
         row_nxt   = '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state_nxt = FILL;
                  col_nxt   = '0;
                  row_nxt   = '0;
               end
            end
            FILL: begin
               if (lb_wen) begin
                  col_nxt = col + 1'b1;
                  if (col == FILL_END) begin
                     state_nxt = STREAM;
                  end
               end
            end
            STREAM: begin
               if (lb_wen) begin
                  if (row_end) begin
                     // Stale taps of the previous row are flushed by
                     // the refill, so no linebuffer clear is needed.
                     col_nxt = '0;
                     if (last_row) begin
                        row_nxt   = '0;
                        state_nxt = DONE;
                     end else begin
                        row_nxt   = row + 1'b1;
                        state_nxt = FILL;
                     end
                  end else begin
                     col_nxt = col + 1'b1;
                  end
               end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_blur_stream_ctrl.sv
// tb_blur_stream_ctrl: directed bench for blur_stream_ctrl with a
// pixel-count model checked every cycle plus literal expectations.
module tb_blur_stream_ctrl;

   localparam int TAPS = 4;
   localparam int W    = 6;
   localparam int L    = 2;

   logic       clk;
   logic       reset;
   logic       start;
   logic       clear;
   logic       in_valid;
   logic       in_ready;
   logic       lb_wen;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       out_frame_last;
   logic       done;
   logic       busy;
   logic [2:0] col;
   logic [0:0] row;

   int total;
   int bad;
   int n_res;
   int n_last;
   int n_flast;
   int n_done;

   bit m_active;
   bit m_donep;
   int m_k;

   blur_stream_ctrl #(
      .TAPS(TAPS),
      .LINE_W(W),
      .NUM_LINES(L)
   ) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .clear(clear),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .lb_wen(lb_wen),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_last(out_last),
      .out_frame_last(out_frame_last),
      .done(done),
      .busy(busy),
      .col(col),
      .row(row)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
      end
   endtask

   // Model: a frame is just a count of accepted pixels; position and
   // window fullness follow from that count by arithmetic.
   always @(negedge clk) begin
      int ecol;
      int erow;
      bit eir;
      bit eov;
      bit elast;
      bit efl;
      bit ewen;
      if (reset) begin
         chk("rst_in_ready", int'(in_ready), 0);
         chk("rst_out_valid", int'(out_valid), 0);
         chk("rst_lb_wen", int'(lb_wen), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_done", int'(done), 0);
         chk("rst_col", int'(col), 0);
         chk("rst_row", int'(row), 0);
         m_active = 0;
         m_donep  = 0;
         m_k      = 0;
      end else begin
         ecol  = m_k % W;
         erow  = m_k / W;
         eir   = m_active && (ecol < TAPS - 1 || out_ready);
         eov   = m_active && ecol >= TAPS - 1 && in_valid;
         elast = eov && ecol == W - 1;
         efl   = elast && erow == L - 1;
         ewen  = in_valid && eir && !clear;
         chk("in_ready", int'(in_ready), int'(eir));
         chk("out_valid", int'(out_valid), int'(eov));
         chk("out_last", int'(out_last), int'(elast));
         chk("out_frame_last", int'(out_frame_last), int'(efl));
         chk("lb_wen", int'(lb_wen), int'(ewen));
         chk("done", int'(done), int'(m_donep));
         chk("busy", int'(busy), int'(m_active));
         chk("col", int'(col), ecol);
         chk("row", int'(row), erow);
         if (out_valid && out_ready) n_res++;
         if (out_valid && out_ready && out_last) n_last++;
         if (out_valid && out_ready && out_frame_last) n_flast++;
         if (done) n_done++;
         if (clear) begin
            m_active = 0;
            m_donep  = 0;
            m_k      = 0;
         end else if (m_donep) begin
            m_donep = 0;
         end else if (!m_active) begin
            if (start) begin
               m_active = 1;
               m_k      = 0;
            end
         end else if (ewen) begin
            m_k++;
            if (m_k == W * L) begin
               m_active = 0;
               m_donep  = 1;
               m_k      = 0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_cnt();
      n_res   = 0;
      n_last  = 0;
      n_flast = 0;
      n_done  = 0;
   endtask

   task automatic wait_done(input int max, input string nm);
      int n = 0;
      while (n_done == 0 && n < max) begin
         tick();
         n++;
      end
      if (n_done == 0) begin
         chk({nm, "_timeout"}, 0, 1);
      end
   endtask

   task automatic frame_totals(input string nm);
      tick();
      chk({nm, "_busy_after"}, int'(busy), 0);
      chk({nm, "_done_after"}, int'(done), 0);
      chk({nm, "_results"}, n_res, 6);
      chk({nm, "_lasts"}, n_last, 2);
      chk({nm, "_frame_lasts"}, n_flast, 1);
      chk({nm, "_done_pulses"}, n_done, 1);
   endtask

   task automatic run_frame(input bit stall, input string nm);
      bit v = 1'b1;
      int n = 0;
      clr_cnt();
      start = 1'b1;
      tick();
      start     = 1'b0;
      out_ready = 1'b1;
      while (n_done == 0 && n < 80) begin
         in_valid = v;
         if (stall) v = ~v;
         tick();
         n++;
      end
      if (n_done == 0) chk({nm, "_timeout"}, 0, 1);
      in_valid = 1'b0;
      frame_totals(nm);
   endtask

   initial begin
      int cseq[7];
      int vseq[7];
      cseq = '{0, 1, 2, 3, 4, 5, 0};
      vseq = '{0, 0, 0, 1, 1, 1, 0};
      total     = 0;
      bad       = 0;
      reset     = 1'b1;
      start     = 1'b0;
      clear     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      clr_cnt();
      repeat (3) tick();
      reset = 1'b0;
      tick();

      // full-throughput frame with literal column/valid sequence
      clr_cnt();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      start     = 1'b1;
      chk("idle_in_ready", int'(in_ready), 0);
      tick();
      start = 1'b0;
      chk("first_in_ready", int'(in_ready), 1);
      for (int i = 0; i < 7; i++) begin
         chk($sformatf("seq_col%0d", i), int'(col), cseq[i]);
         chk($sformatf("seq_ov%0d", i), int'(out_valid), vseq[i]);
         chk($sformatf("seq_last%0d", i), int'(out_last), int'(i == 5));
         tick();
      end
      wait_done(20, "frame1");
      in_valid = 1'b0;
      frame_totals("frame1");

      // backpressure in FILL and in STREAM
      clr_cnt();
      start = 1'b1;
      tick();
      start     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("fill_ignores_sink", int'(in_ready), 1);
         tick();
      end
      for (int i = 0; i < 3; i++) begin
         chk("bp_in_ready", int'(in_ready), 0);
         chk("bp_lb_wen", int'(lb_wen), 0);
         chk("bp_col_hold", int'(col), 3);
         tick();
      end
      out_ready = 1'b1;
      wait_done(30, "bp");
      in_valid = 1'b0;
      frame_totals("bp");

      // start ignored while streaming; clear aborts mid-row
      clr_cnt();
      start = 1'b1;
      tick();
      in_valid  = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         start = (i == 4);
         tick();
      end
      start = 1'b0;
      chk("abort_col", int'(col), 3);
      chk("abort_row", int'(row), 1);
      chk("abort_results", n_res, 3);
      clear = 1'b1;
      #1;
      chk("clear_no_wen", int'(lb_wen), 0);
      tick();
      clear    = 1'b0;
      in_valid = 1'b0;
      chk("clear_col", int'(col), 0);
      chk("clear_row", int'(row), 0);
      chk("clear_busy", int'(busy), 0);
      run_frame(1'b0, "after_clear");

      // source stalls
      run_frame(1'b1, "stall");

      // asynchronous reset mid-row
      start = 1'b1;
      tick();
      start     = 1'b0;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      repeat (4) tick();
      #2;
      reset = 1'b1;
      #1;
      chk("arst_in_ready", int'(in_ready), 0);
      chk("arst_out_valid", int'(out_valid), 0);
      chk("arst_lb_wen", int'(lb_wen), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_col", int'(col), 0);
      chk("arst_row", int'(row), 0);
      tick();
      reset    = 1'b0;
      in_valid = 1'b0;
      tick();
      run_frame(1'b0, "after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
